fpmul_issue_arb: RTL
====================

Name: fpmul_issue_arb

Overview:
Round-robin issue scheduler that shares one single-precision FP multiplier pipeline (33-bit internal format, fixed latency) among NREQ requesters. It drives the multiplier operand and enable inputs, and tracks in-flight operations with a valid/id/tag shift register. Returned results are captured with their raise flags in a credit-protected result FIFO, which drains to one result bus with valid/ready.

Parameters:
NREQ, 4, number of requesters (2..8)
LAT, 2, multiplier latency in cycles from mul_en issue to mul_res/mul_raise valid
FIFO_DEPTH, 4, result FIFO entries (power of 2, >= LAT)
TAGW, 4, per-request tag width

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  asynchronous, active-low reset
req_valid  in  NREQ  request pending, one bit per requester
req_ready  out  NREQ  one-hot grant this cycle
req_A  in  NREQ*33  operand A per requester (slice i = bits 33i+32:33i)
req_B  in  NREQ*33  operand B per requester
req_copyA  in  NREQ  copy-A operation per requester
req_rmode  in  NREQ*3  rounding mode per requester
req_tag  in  NREQ*TAGW  request tag per requester
flush  in  1  discards all in-flight and queued results
mul_A  out  33  operand A to the multiplier
mul_B  out  33  operand B to the multiplier
mul_copyA  out  1  copyA to the multiplier
mul_rmode  out  3  rmode to the multiplier
mul_en  out  1  issue strobe to the multiplier
mul_res  in  33  multiplier result
mul_raise  in  11  multiplier exception flags
res_valid  out  1  FIFO head valid
res_ready  in  1  consumer accepts the head
res_data  out  33  head result
res_raise  out  11  head flags
res_req_id  out  $clog2(NREQ)  originating requester
res_tag  out  TAGW  originating tag
busy  out  1  any in-flight or queued entry

Behaviour:
- Reset (rst=0, asynchronous): RR pointer=0, in-flight valids=0, FIFO rd/wr pointers and count=0. Outputs while reset is held: res_valid=0, mul_en=0, req_ready=0, busy=0, mul_A/mul_B/mul_rmode=0, mul_copyA=0. Any in-flight operation is lost.
- Credit check: can_issue = ~flush & (fifo_count + inflight_count < FIFO_DEPTH). Both counts are registered values, so the check is conservative and ignores a pop in the same cycle.
- Arbitration (combinational): when can_issue, grant goes to the first i with req_valid[i], scanning from ptr upward with wrap-around. req_ready = that one-hot grant; all zeros when can_issue=0 or no request is pending.
- Issue: mul_en = |req_ready. mul_A, mul_B, mul_copyA and mul_rmode are muxed from the granted slice; all zeros when there is no grant. A transfer happens when req_valid[i] & req_ready[i] in the same cycle.
- Pointer update: after a grant to i, ptr <= (i+1) mod NREQ. The pointer holds when there is no grant.
- Tracking: an LAT-stage shift register carries {valid, id, tag}. Stage 0 loads the grant each cycle. inflight_count = number of valid stages.
- Return: when the last stage is valid, {mul_res, mul_raise, id, tag} is written to the FIFO at the next posedge. The credit check guarantees no overflow; the bench asserts it.
- Drain: res_* come from the FIFO head. Pop on res_valid & res_ready. A write and a pop in the same cycle leave the count unchanged. There is no bypass, so a result reaches res_valid LAT+1 cycles after its grant cycle.
- Flush: all shift-register valids and the FIFO are cleared at the next posedge, and no grant is made that cycle. A pop in the flush cycle is still reported on res_* but the entry is discarded. A return arriving in the flush cycle is dropped.
- busy = (inflight_count != 0) | (fifo_count != 0).
- Pointer arithmetic: counters are $clog2(FIFO_DEPTH)+1 bits wide. FIFO read and write pointers wrap modulo FIFO_DEPTH.

Test Plan:
- Stub multiplier returns A^B after LAT=2. Requester 1 alone issues A=0x1_0000_0001, B=0x0_0000_0003, tag=5, res_ready=1 → req_ready=0010 in cycle 0; res_valid=1 in cycle 3 with res_data=0x1_0000_0002, res_req_id=1, res_tag=5.
- All 4 requesters hold req_valid=1 for 8 cycles, res_ready=1 → grant order 0,1,2,3,0,1,2,3; results in the same order; mul_en=1 every cycle after credits are available.
- res_ready=0, requester 0 streams → exactly 4 grants (FIFO_DEPTH) then req_ready=0. Raising res_ready drains 4 results in order, then issue resumes.
- flush asserted while 2 ops are in flight and 1 is queued → the flush cycle has no grant; no res_valid afterwards; busy=0 two cycles later; the next request issues normally.
- Reset pulse while 3 ops are in flight → res_valid, mul_en and busy are 0 immediately. After release the next grant starts from requester 0 and no stale results appear.
- A FIFO write and a pop in the same cycle with fifo_count=2 → count stays 2 and data ordering is preserved.

Source files
------------

// File: rtl/fpmul_issue_arb_if.sv
// Bundle between the fpmul issue arbiter and its environment: requesters,
// the shared multiplier and the result consumer.
interface fpmul_issue_arb_if #(
    parameter int NREQ = 4,
    parameter int TAGW = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0]            req_ready;
    logic [NREQ-1:0][32:0]      req_A;
    logic [NREQ-1:0][32:0]      req_B;
    logic [NREQ-1:0]            req_copyA;
    logic [NREQ-1:0][2:0]       req_rmode;
    logic [NREQ-1:0][TAGW-1:0]  req_tag;
    logic                       flush;

    logic [32:0]                mul_A;
    logic [32:0]                mul_B;
    logic                       mul_copyA;
    logic [2:0]                 mul_rmode;
    logic                       mul_en;
    logic [32:0]                mul_res;
    logic [10:0]                mul_raise;

    logic                       res_valid;
    logic                       res_ready;
    logic [32:0]                res_data;
    logic [10:0]                res_raise;
    logic [IDW-1:0]             res_req_id;
    logic [TAGW-1:0]            res_tag;
    logic                       busy;

    modport master (
        output req_valid, req_A, req_B, req_copyA, req_rmode, req_tag, flush,
               mul_res, mul_raise, res_ready,
        input  req_ready, mul_A, mul_B, mul_copyA, mul_rmode, mul_en,
               res_valid, res_data, res_raise, res_req_id, res_tag, busy
    );

    modport slave (
        input  req_valid, req_A, req_B, req_copyA, req_rmode, req_tag, flush,
               mul_res, mul_raise, res_ready,
        output req_ready, mul_A, mul_B, mul_copyA, mul_rmode, mul_en,
               res_valid, res_data, res_raise, res_req_id, res_tag, busy
    );
endinterface

// File: rtl/fpmul_issue_arb.sv
// Round-robin issue of NREQ requesters into one fixed-latency FP multiplier,
// with in-flight tracking and a credit-protected result FIFO.
module fpmul_issue_arb #(
    parameter int NREQ       = 4,
    parameter int LAT        = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int TAGW       = 4
) (
    input logic clk,
    input logic rst,
    fpmul_issue_arb_if.slave bus
);
    localparam int IDW = $clog2(NREQ);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;

    typedef struct packed {
        logic [32:0]     res;
        logic [10:0]     raise;
        logic [IDW-1:0]  id;
        logic [TAGW-1:0] tag;
    } ent_t;

    logic [IDW-1:0]             ptr;
    logic [LAT-1:0]             vld_pipe;
    logic [LAT-1:0][IDW-1:0]    id_pipe;
    logic [LAT-1:0][TAGW-1:0]   tag_pipe;
    ent_t                       mem [FIFO_DEPTH];
    logic [AW-1:0]              rd_ptr, wr_ptr;
    logic [CW-1:0]              fifo_cnt, infl_cnt;
    logic                       can_issue, gnt_any, fifo_wr, fifo_rd;
    logic [NREQ-1:0]            gnt;
    logic [IDW-1:0]             gnt_id;
    ent_t                       head;

    always_comb begin
        infl_cnt = '0;
        for (int s = 0; s < LAT; s++) infl_cnt = infl_cnt + CW'(vld_pipe[s]);
    end

    // Registered counts only: a same-cycle pop does not free a credit.
    assign can_issue = rst & ~bus.flush &
        (((CW+1)'(fifo_cnt) + (CW+1)'(infl_cnt)) < (CW+1)'(FIFO_DEPTH));

    always_comb begin
        int idx;
        gnt     = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (can_issue && !gnt_any && bus.req_valid[idx]) begin
                gnt_any     = 1'b1;
                gnt[idx]    = 1'b1;
                gnt_id      = IDW'(idx);
            end
        end
    end

    assign bus.req_ready = gnt;
    assign bus.mul_en    = gnt_any;
    assign bus.mul_A     = gnt_any ? bus.req_A[gnt_id]     : '0;
    assign bus.mul_B     = gnt_any ? bus.req_B[gnt_id]     : '0;
    assign bus.mul_copyA = gnt_any & bus.req_copyA[gnt_id];
    assign bus.mul_rmode = gnt_any ? bus.req_rmode[gnt_id] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         ptr <= '0;
        else if (gnt_any) ptr <= (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe <= '0;
            id_pipe  <= '0;
            tag_pipe <= '0;
        end else begin
            vld_pipe[0] <= gnt_any;
            id_pipe[0]  <= gnt_id;
            tag_pipe[0] <= bus.req_tag[gnt_id];
            for (int s = 1; s < LAT; s++) begin
                vld_pipe[s] <= vld_pipe[s-1] & ~bus.flush;
                id_pipe[s]  <= id_pipe[s-1];
                tag_pipe[s] <= tag_pipe[s-1];
            end
        end
    end

    // Last tracking stage lines up with mul_res/mul_raise.
    assign fifo_wr = vld_pipe[LAT-1] & ~bus.flush;
    assign fifo_rd = bus.res_valid & bus.res_ready & ~bus.flush;

    always_ff @(posedge clk) begin
        if (fifo_wr)
            mem[wr_ptr] <= '{res: bus.mul_res, raise: bus.mul_raise,
                             id: id_pipe[LAT-1], tag: tag_pipe[LAT-1]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (bus.flush) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
            if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({fifo_wr, fifo_rd})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    assign head           = mem[rd_ptr];
    assign bus.res_valid  = (fifo_cnt != '0);
    assign bus.res_data   = head.res;
    assign bus.res_raise  = head.raise;
    assign bus.res_req_id = head.id;
    assign bus.res_tag    = head.tag;
    assign bus.busy       = (infl_cnt != '0) | (fifo_cnt != '0);
endmodule
